// File: rtl/layer_argmax_seq.sv
// layer_argmax_seq
// Sequential argmax over the NUM_IN post-ReLU outputs of the final dense
// layer of the ECG classifier. A packed vector is accepted through a
// valid/ready handshake and captured internally. One element is then compared
// per clock on a single comparator. The index of the largest element is
// reported as the predicted class and held until the consumer takes it.
//
// Ports
//   i_clk        rising-edge clock
//   i_reset      asynchronous active-low reset (0 = reset asserted)
//   i_in_valid   i_in_vec holds a complete layer result
//   o_in_ready   block can accept a vector (IDLE only)
//   i_in_vec     packed node outputs, element k = i_in_vec[k*DATA_W +: DATA_W]
//   o_out_valid  o_out_class (and o_out_score) valid
//   i_out_ready  consumer accepts the result
//   o_out_class  index of the maximum element
//   o_busy       high in SCAN or HOLD
//   o_out_score  value of the maximum element (only with ARGMAX_SCORE_EN)
//
// Build option
//   ARGMAX_SCORE_EN  adds the o_out_score output port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a vector; o_in_ready=1
// SCAN  | comparing element[cnt] against the running best, one per clock
// HOLD  | result presented on o_out_valid/o_out_class until i_out_ready

module layer_argmax_seq #(
  parameter int NUM_IN = 12,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [NUM_IN*DATA_W-1:0] i_in_vec,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [IDX_W-1:0]         o_out_class,
  output logic                     o_busy
`ifdef ARGMAX_SCORE_EN
  ,
  output logic [DATA_W-1:0]        o_out_score
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]              r_state;
  logic [NUM_IN*DATA_W-1:0] r_vec;
  logic [DATA_W-1:0]       r_best_val;
  logic [IDX_W-1:0]        r_best_idx;
  logic [IDX_W-1:0]        r_cnt;

  logic [DATA_W-1:0]       w_elem;
  logic                    w_last;
  logic                    w_better;

  // Element select from the captured vector. Written as a compare-per-slot
  // mux so that counter values beyond NUM_IN-1 read as zero, not out of range.
  always_comb begin
    w_elem = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (r_cnt == IDX_W'(k)) begin
        w_elem = r_vec[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_last   = (r_cnt == IDX_W'(NUM_IN - 1));
  // A strict compare makes ties keep the earlier (lower) index.
  assign w_better = (w_elem > r_best_val);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_vec      <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_vec      <= i_in_vec;
            r_best_val <= i_in_vec[DATA_W-1:0];
            r_best_idx <= '0;
            r_cnt      <= IDX_W'(1);
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_better) begin
            r_best_val <= w_elem;
            r_best_idx <= r_cnt;
          end
          if (w_last) begin
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_HOLD);
  assign o_busy      = (r_state == S_SCAN) || (r_state == S_HOLD);
  assign o_out_class = r_best_idx;

`ifdef ARGMAX_SCORE_EN
  assign o_out_score = r_best_val;
`endif

endmodule

// File: tb/tb_layer_argmax_seq.sv
module tb_layer_argmax_seq;

  localparam int NUM_IN = 12;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 4;
  localparam int VW     = NUM_IN * DATA_W;
  localparam int LAT    = NUM_IN - 1;

  logic              i_clk;
  logic              i_reset;
  logic              i_in_valid;
  logic              o_in_ready;
  logic [VW-1:0]     i_in_vec;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [IDX_W-1:0]  o_out_class;
  logic              o_busy;
`ifdef ARGMAX_SCORE_EN
  logic [DATA_W-1:0] o_out_score;
`endif

  layer_argmax_seq #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_vec    (i_in_vec),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_class (o_out_class),
    .o_busy      (o_busy)
`ifdef ARGMAX_SCORE_EN
    ,
    .o_out_score (o_out_score)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef logic [DATA_W-1:0] elem_arr_t [NUM_IN];

  typedef struct {
    string             name;
    logic [VW-1:0]     vec;
    logic [IDX_W-1:0]  exp_class;
    logic [DATA_W-1:0] exp_score;
  } vec_rec_t;

  vec_rec_t tv[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [VW-1:0] pack(input elem_arr_t e);
    logic [VW-1:0] v;
    for (int k = 0; k < NUM_IN; k++) v[k*DATA_W +: DATA_W] = e[k];
    return v;
  endfunction

  // Reference: first index holding the maximum unsigned value.
  function automatic int ref_argmax(input logic [VW-1:0] v);
    int best = 0;
    int bestv = int'(v[DATA_W-1:0]);
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(v[k*DATA_W +: DATA_W]) > bestv) begin
        bestv = int'(v[k*DATA_W +: DATA_W]);
        best  = k;
      end
    end
    return best;
  endfunction

  // Present a vector at a negedge; it is accepted on the next posedge.
  task automatic accept(input string nm, input logic [VW-1:0] v);
    check({nm, "_in_ready"}, {31'd0, o_in_ready}, 32'd1);
    i_in_valid = 1'b1;
    i_in_vec   = v;
    @(negedge i_clk);
    i_in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid rises (bounded).
  task automatic wait_result(input bit scramble, output int lat);
    lat = 0;
    while (!o_out_valid && lat < 4 * NUM_IN) begin
      if (scramble) i_in_vec = {$urandom, $urandom, $urandom};
      @(negedge i_clk);
      lat++;
    end
  endtask

  task automatic check_result(input string nm, input int lat,
                              input logic [IDX_W-1:0] ec, input logic [DATA_W-1:0] es);
    check({nm, "_latency"}, lat, LAT);
    check({nm, "_class"}, {28'd0, o_out_class}, {28'd0, ec});
`ifdef ARGMAX_SCORE_EN
    check({nm, "_score"}, {24'd0, o_out_score}, {24'd0, es});
`else
    if (es == 8'hxx) $display("unused %0h", es);
`endif
  endtask

  task automatic release_out(input string nm);
    i_out_ready = 1'b1;
    @(negedge i_clk);
    i_out_ready = 1'b0;
    check({nm, "_valid_drop"}, {31'd0, o_out_valid}, 32'd0);
    check({nm, "_ready_back"}, {31'd0, o_in_ready}, 32'd1);
  endtask

  initial begin
    elem_arr_t e;
    logic [VW-1:0] v, v2;
    logic [IDX_W-1:0] held;
    int lat;
    int ec;

    // Directed table, expectations hand-derived.
    for (int k = 0; k < NUM_IN; k++) e[k] = 8'(k * 4);
    e[7] = 8'h70;
    tv[0] = '{"basic", pack(e), 4'd7, 8'h70};
    for (int k = 0; k < NUM_IN; k++) e[k] = 8'h10;
    e[3] = 8'h55; e[9] = 8'h55;
    tv[1] = '{"tie", pack(e), 4'd3, 8'h55};
    for (int k = 0; k < NUM_IN; k++) e[k] = 8'h00;
    tv[2] = '{"zeros", pack(e), 4'd0, 8'h00};
    e[11] = 8'h01;
    tv[3] = '{"last", pack(e), 4'd11, 8'h01};
    for (int k = 0; k < NUM_IN; k++) e[k] = 8'h20;
    e[2] = 8'h7F; e[5] = 8'h80;
    tv[4] = '{"unsigned", pack(e), 4'd5, 8'h80};

    i_reset = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0; i_in_vec = '0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_class", {28'd0, o_out_class}, 32'd0);

    // out_ready while idle must be ignored.
    i_out_ready = 1'b1;
    @(negedge i_clk);
    i_out_ready = 1'b0;
    check("idle_out_ready_ignored", {31'd0, o_out_valid}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      accept(tv[i].name, tv[i].vec);
      check({tv[i].name, "_busy"}, {31'd0, o_busy}, 32'd1);
      wait_result(1'b0, lat);
      check_result(tv[i].name, lat, tv[i].exp_class, tv[i].exp_score);
      release_out(tv[i].name);
    end

    // Backpressure with a second vector waiting on in_valid.
    for (int k = 0; k < NUM_IN; k++) e[k] = 8'h05;
    e[4] = 8'h66;
    v = pack(e);
    for (int k = 0; k < NUM_IN; k++) e[k] = 8'h01;
    e[10] = 8'h3C;
    v2 = pack(e);
    accept("bp1", v);
    wait_result(1'b0, lat);
    check_result("bp1", lat, 4'd4, 8'h66);
    held = o_out_class;
    i_in_valid = 1'b1;
    i_in_vec = v2;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      check("bp_valid_held", {31'd0, o_out_valid}, 32'd1);
      check("bp_class_held", {28'd0, o_out_class}, {28'd0, held});
      check("bp_in_ready_low", {31'd0, o_in_ready}, 32'd0);
    end
    i_out_ready = 1'b1;
    @(negedge i_clk);
    i_out_ready = 1'b0;
    check("bp_release_valid", {31'd0, o_out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, o_in_ready}, 32'd1);
    @(negedge i_clk);
    i_in_valid = 1'b0;
    check("bp2_accepted", {31'd0, o_busy & ~o_in_ready}, 32'd1);
    wait_result(1'b1, lat);
    check_result("bp2", lat, 4'd10, 8'h3C);
    release_out("bp2");

    // Input changes during SCAN must not matter.
    for (int k = 0; k < NUM_IN; k++) e[k] = 8'(k + 1);
    e[6] = 8'h77;
    accept("stable", pack(e));
    wait_result(1'b1, lat);
    check_result("stable", lat, 4'd6, 8'h77);
    release_out("stable");

    // Reset in the middle of SCAN.
    for (int k = 0; k < NUM_IN; k++) e[k] = 8'h00;
    e[9] = 8'h7E;
    accept("midrst", pack(e));
    repeat (4) @(negedge i_clk);
    #2 i_reset = 1'b0;
    #1;
    check("midrst_valid", {31'd0, o_out_valid}, 32'd0);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_in_ready", {31'd0, o_in_ready}, 32'd1);
    check("midrst_class", {28'd0, o_out_class}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    for (int k = 0; k < NUM_IN; k++) e[k] = 8'h11;
    e[2] = 8'h6A;
    accept("postrst", pack(e));
    wait_result(1'b0, lat);
    check_result("postrst", lat, 4'd2, 8'h6A);
    release_out("postrst");

    // Randomized vectors against the reference model; narrow ranges force ties.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NUM_IN; k++)
        e[k] = (i % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      v = pack(e);
      ec = ref_argmax(v);
      accept("rand", v);
      wait_result(i % 3 == 0, lat);
      check_result("rand", lat, 4'(ec), v[ec*DATA_W +: DATA_W]);
      if (i % 4 == 1) repeat ($urandom_range(1, 3)) @(negedge i_clk);
      release_out("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/layer_argmax_seq.md
Name: layer_argmax_seq

Overview:
- Downstream consumer of the final dense layer of the ECG classifier.
- Takes the layer's NUM_IN post-ReLU 8-bit node outputs as one packed vector with a valid/ready handshake.
- Scans the vector sequentially, one element per clock, and reports the index of the largest activation as the predicted class.
- Trades latency for area: one comparator, no comparator tree.

Parameters:
- NUM_IN, 12, number of node outputs (classes); legal range 2 to 2**IDX_W.
- DATA_W, 8, width of each node output.
- IDX_W, 4, width of the class index; must satisfy 2**IDX_W >= NUM_IN.

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-low reset (0 = reset asserted).
- in_valid, in, 1, in_vec holds a complete layer result.
- in_ready, out, 1, block can accept a vector.
- in_vec, in, NUM_IN*DATA_W, packed node outputs; element k = in_vec[k*DATA_W +: DATA_W].
- out_valid, out, 1, out_class (and out_score) valid.
- out_ready, in, 1, consumer accepts the result.
- out_class, out, IDX_W, index of the maximum element.
- busy, out, 1, high in SCAN or HOLD.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; out_valid=0, out_class=0, busy=0, in_ready=1; the internal captured vector, best_val, best_idx and cnt are cleared to 0.
- Reset is asynchronous on assertion. Release is sampled on clk.
- A reset during SCAN or HOLD aborts the operation immediately and the result is discarded.

State machine:
- IDLE:
  - in_ready=1.
  - A transfer occurs on an edge with in_valid=1 and in_ready=1.
  - On that edge: capture in_vec into an internal register; best_val<=element 0; best_idx<=0; cnt<=1; go to SCAN.
- SCAN:
  - in_ready=0.
  - Each edge compares element[cnt] with best_val.
  - If element[cnt] > best_val (strict, unsigned), then best_val<=element[cnt] and best_idx<=cnt.
  - If cnt==NUM_IN-1, go to HOLD; otherwise cnt<=cnt+1.
- HOLD:
  - in_ready=0, out_valid=1; out_class=best_idx, held stable.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.

Handshakes and timing:
- Latency: out_valid rises NUM_IN-1 edges after the accepting edge (11 cycles for NUM_IN=12).
- Throughput: one vector per NUM_IN+1 cycles at best. There is no overlap; in_ready stays low until HOLD is exited.
- in_valid asserted while in_ready=0 is ignored. Upstream must hold the data.
- in_vec changes after the accepting edge have no effect, because the vector is captured.
- out_ready while out_valid=0 is ignored.
- Once asserted, out_valid stays high until the handshake completes.

Arithmetic:
- Comparison is unsigned DATA_W-bit, so 0x80..0xFF rank above 0x7F, even though the upstream ReLU yields only 0x00..0x7F.

Boundary conditions:
- Ties resolve to the lowest index, because the comparison is strict.
- An all-zero vector gives out_class=0.
- If the maximum is in the last element, the update happens on the final SCAN edge and out_class is correct in the first HOLD cycle.

Optional Feature:
- Macro ARGMAX_SCORE_EN.
- When defined: an extra output port out_score [DATA_W-1:0] equals best_val and is valid whenever out_valid=1. It is reset to 0 and held stable in HOLD.
- When undefined: the out_score port does not exist, and best_val is internal only.

Test Plan:
- Reset check: hold reset=0 for 3 cycles, then release → in_ready=1, out_valid=0, busy=0, out_class=0.
- Basic max: element k = k*4 except element 7 = 0x70, out_ready=1 → out_valid exactly 11 cycles after the accept with out_class=7; out_score=0x70 when ARGMAX_SCORE_EN is defined.
- Ties and edges:
  - element 3 = element 9 = 0x55, all others 0x10 → out_class=3.
  - all zeros → out_class=0.
  - only element 11 = 0x01 → out_class=11.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises, while in_valid is held high with a new vector → out_valid and out_class stable, in_ready=0. When out_ready=1, exactly one cycle later in_ready=1 and the second vector is accepted.
- Input stability: change in_vec every cycle during SCAN → result matches the vector captured on the accepting edge.
- Reset mid-scan: assert reset=0 at cycle 5 of SCAN → out_valid=0, busy=0, in_ready=1 immediately. The next vector, with max at element 2, yields out_class=2.
